// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
// Bundles every handshake/bus signal around the unified memory-port arbiter.
//   fetch side : ifreq, ifaddr -> ifrdata, ifready
//   data side  : dreq, dwe, dbe, daddr, dwdata -> drdata, dready
//   memory side: mreq, mwe, mbe, maddr, mwdata <- mrdata, mack
//   status     : buserr (sticky watchdog abort flag)
// Modports:
//   master - the arbiter itself (owns the memory port, answers both requesters)
//   slave  - everything around it (pipeline requesters and the memory)
interface mem_port_arbiter_if;
  logic        ifreq;
  logic [31:0] ifaddr;
  logic [31:0] ifrdata;
  logic        ifready;

  logic        dreq;
  logic        dwe;
  logic [3:0]  dbe;
  logic [31:0] daddr;
  logic [31:0] dwdata;
  logic [31:0] drdata;
  logic        dready;

  logic        mreq;
  logic        mwe;
  logic [3:0]  mbe;
  logic [31:0] maddr;
  logic [31:0] mwdata;
  logic [31:0] mrdata;
  logic        mack;

  logic        buserr;

  modport master (
    input  ifreq, ifaddr, dreq, dwe, dbe, daddr, dwdata, mrdata, mack,
    output ifrdata, ifready, drdata, dready, mreq, mwe, mbe, maddr, mwdata, buserr
  );

  modport slave (
    output ifreq, ifaddr, dreq, dwe, dbe, daddr, dwdata, mrdata, mack,
    input  ifrdata, ifready, drdata, dready, mreq, mwe, mbe, maddr, mwdata, buserr
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one memory port between the fetch stage and the memory stage with fixed
// data-first priority, one transaction at a time. Address/control/data are latched
// at grant, the access waits for mack, and the result returns with a one-cycle ready
// pulse. A watchdog aborts an access that sees no mack for TIMEOUT busy cycles,
// returns ERR_DATA and sets the sticky buserr flag.
// Ports:
//   clk   - clock, all state on the rising edge
//   reset - asynchronous active-low reset
//   bus   - mem_port_arbiter_if.master (fetch, data and memory handshakes, buserr)
module mem_port_arbiter #(
  parameter logic [15:0] TIMEOUT  = 16'd255,
  parameter logic [31:0] ERR_DATA = 32'h0000_0000
) (
  input logic                clk,
  input logic                reset,
  mem_port_arbiter_if.master bus
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIBusy = 2'd1,
    StDBusy = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] wdog_q, wdog_d;
  logic        mreq_q;
  logic        mwe_q, mwe_d;
  logic [3:0]  mbe_q, mbe_d;
  logic [31:0] maddr_q, maddr_d;
  logic [31:0] mwdata_q, mwdata_d;
  logic [31:0] ifrdata_q, ifrdata_d;
  logic [31:0] drdata_q, drdata_d;
  logic        ifready_q, ifready_d;
  logic        dready_q, dready_d;
  logic        buserr_q, buserr_d;

  logic        busy, abort, done, arb;
  logic        i_ok, d_ok, grant_i, grant_d;
  logic [31:0] rdata;

  always_comb begin
    state_d   = state_q;
    wdog_d    = wdog_q;
    mwe_d     = mwe_q;
    mbe_d     = mbe_q;
    maddr_d   = maddr_q;
    mwdata_d  = mwdata_q;
    ifrdata_d = ifrdata_q;
    drdata_d  = drdata_q;
    ifready_d = 1'b0;
    dready_d  = 1'b0;
    buserr_d  = buserr_q;

    busy  = (state_q != StIdle);
    abort = busy && !bus.mack && (TIMEOUT != 16'd0) && (wdog_q == TIMEOUT - 16'd1);
    done  = busy && (bus.mack || abort);
    rdata = bus.mack ? bus.mrdata : ERR_DATA;

    // A requester keeps req high through its ready cycle, so it is not eligible
    // while being completed nor while its ready pulse is up; otherwise the same
    // access would be issued twice.
    i_ok = bus.ifreq && !ifready_q && !(done && (state_q == StIBusy));
    d_ok = bus.dreq && !dready_q && !(done && (state_q == StDBusy));

    // Abort forces one IDLE cycle so mreq visibly drops.
    arb     = (state_q == StIdle) || (done && !abort);
    grant_d = arb && d_ok;
    grant_i = arb && !d_ok && i_ok;

    if (done) begin
      state_d = StIdle;
    end
    if (grant_d) begin
      state_d  = StDBusy;
      maddr_d  = bus.daddr;
      mwe_d    = bus.dwe;
      mbe_d    = bus.dwe ? bus.dbe : 4'hF;
      mwdata_d = bus.dwdata;
    end else if (grant_i) begin
      state_d = StIBusy;
      maddr_d = bus.ifaddr;
      mwe_d   = 1'b0;
      mbe_d   = 4'hF;
    end

    if ((state_d == StIdle) || grant_d || grant_i) begin
      wdog_d = 16'd0;
    end else if (!bus.mack && (TIMEOUT != 16'd0)) begin
      wdog_d = wdog_q + 16'd1;
    end

    if (done && (state_q == StIBusy)) begin
      ifready_d = 1'b1;
      ifrdata_d = rdata;
    end
    if (done && (state_q == StDBusy)) begin
      dready_d = 1'b1;
      drdata_d = mwe_q ? 32'h0000_0000 : rdata;
    end

    if (abort) begin
      buserr_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      wdog_q    <= 16'd0;
      mreq_q    <= 1'b0;
      mwe_q     <= 1'b0;
      mbe_q     <= 4'h0;
      maddr_q   <= 32'h0;
      mwdata_q  <= 32'h0;
      ifrdata_q <= 32'h0;
      drdata_q  <= 32'h0;
      ifready_q <= 1'b0;
      dready_q  <= 1'b0;
      buserr_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      wdog_q    <= wdog_d;
      mreq_q    <= (state_d != StIdle);
      mwe_q     <= mwe_d;
      mbe_q     <= mbe_d;
      maddr_q   <= maddr_d;
      mwdata_q  <= mwdata_d;
      ifrdata_q <= ifrdata_d;
      drdata_q  <= drdata_d;
      ifready_q <= ifready_d;
      dready_q  <= dready_d;
      buserr_q  <= buserr_d;
    end
  end

  assign bus.mreq    = mreq_q;
  assign bus.mwe     = mwe_q;
  assign bus.mbe     = mbe_q;
  assign bus.maddr   = maddr_q;
  assign bus.mwdata  = mwdata_q;
  assign bus.ifrdata = ifrdata_q;
  assign bus.ifready = ifready_q;
  assign bus.drdata  = drdata_q;
  assign bus.dready  = dready_q;
  assign bus.buserr  = buserr_q;

endmodule
